// File: rtl/csa_pkg.sv
// Shared definitions for the serial carry-select / decrement block adder.
//   W_DEF, B_DEF : default operand width and block width
//   state_e      : FSM state encoding used by csa_dec_serial (and visible on
//                  its dbg_state port)
package csa_pkg;

  localparam int W_DEF = 16;
  localparam int B_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/csa_dec_serial_rb_dec.sv
// rb_dec: combinational block decrement.
// Given a speculative block sum s = x + 1, recovers x = s - 1 bitwise:
//   bit 0 = ~s[0]
//   bit i = s[i] ^ (all of s[i-1:0] are zero)
// Ports:
//   s_i [B-1:0] : speculative low bits of the block sum
//   d_o [B-1:0] : decremented value
module rb_dec #(
  parameter int B = 4
) (
  input  logic [B-1:0] s_i,
  output logic [B-1:0] d_o
);

  // zero_below tracks "every lower bit of s_i is zero" as the loop walks up,
  // i.e. whether the borrow from the -1 still reaches bit i.
  always_comb begin
    logic zero_below;
    zero_below = 1'b1;
    d_o        = '0;
    for (int i = 0; i < B; i++) begin
      d_o[i]     = s_i[i] ^ zero_below;
      zero_below = zero_below & ~s_i[i];
    end
  end

endmodule

// File: rtl/csa_dec_serial.sv
// csa_dec_serial: W-bit adder computed serially, one B-bit block per cycle.
// Each block always forms a+b+1; if the incoming carry is 0 the block result
// is the decrement of that speculative sum (rb_dec), and the carry-out is
// adjusted accordingly.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1 (in_valid/in_ready on the input side, out_valid/out_ready on
// the output side). Operands are captured on the input transfer edge; the
// result is held stable from out_valid rising until the output transfer.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid/in_ready : operand handshake (in_ready is registered)
//   a, b, cin         : operands
//   out_valid/out_ready : result handshake (out_valid is registered)
//   sum, cout         : (a+b+cin) mod 2^W and bit W of a+b+cin
//   dbg_state         : current FSM state (csa_pkg::state_e encoding)
module csa_dec_serial
  import csa_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int B = B_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [1:0]   dbg_state
);

  if (B < 1 || W < 1 || (W % B) != 0) begin : g_bad_param
    $error("csa_dec_serial: W must be a nonzero multiple of B");
  end

  localparam int NB = W / B;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          accept;
  logic          last_blk;
  logic [B:0]    s1;
  logic [B-1:0]  s1_dec;
  logic [B-1:0]  slice;
  logic          c_next;

  assign accept   = (state_q == ST_IDLE) && in_ready_q && in_valid;
  assign last_blk = (k_q == K_LAST);

  // Speculative block sum assuming a carry-in of 1.
  always_comb begin
    s1 = {1'b0, a_q[k_q*B +: B]} + {1'b0, b_q[k_q*B +: B]} + {{B{1'b0}}, 1'b1};
  end

  rb_dec #(.B(B)) u_rb_dec (
    .s_i (s1[B-1:0]),
    .d_o (s1_dec)
  );

  // With carry-in 0 the true sum is s1-1: it overflows only if s1 exceeded
  // 2^B, i.e. s1[B] set and the low bits nonzero.
  assign slice  = c_q ? s1[B-1:0] : s1_dec;
  assign c_next = c_q ? s1[B] : (s1[B] & (|s1[B-1:0]));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      c_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_CALC;
      ST_CALC: if (last_blk)  state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values. The handshake flags are registered
  // copies of the upcoming state, so they are never both high.
  always_comb begin
    k_d         = k_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d = a;
          b_d = b;
          c_d = cin;
          k_d = '0;
        end
      end
      ST_CALC: begin
        sum_d[k_q*B +: B] = slice;
        c_d = c_next;
        if (last_blk) begin
          k_d    = '0;
          cout_d = c_next;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: doc/csa_dec_serial.md
CSA_DEC_SERIAL -- requirements
Module: csa_dec_serial

Interface
REQ-001 SHALL have parameter W, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter B, default 4: block width in bits; NB = W/B blocks.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operands offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have port a, input, W bits: addend A.
REQ-008 SHALL have port b, input, W bits: addend B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in.
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-012 SHALL have port sum, output, W bits: result (a+b+cin) mod 2^W.
REQ-013 SHALL have port cout, output, 1 bit: carry-out of the W-bit addition.

Function
REQ-014 SHALL require W to be a nonzero multiple of B; any other value is an elaboration error.
REQ-015 SHALL implement a three-state FSM: IDLE, CALC, HOLD.
REQ-016 SHALL, in IDLE, drive in_ready=1; on in_valid=1, register a, b and cin, set block index k=0 and carry register c=cin, then go to CALC.
REQ-017 SHALL, on each CALC cycle, compute speculative block sum s1 = a_k + b_k + 1 as B+1 bits (a_k, b_k = bits [kB+B-1:kB]).
REQ-018 SHALL, in that CALC cycle, write sum slice k = s1[B-1:0] when c=1; when c=0, write the decrement recompute of s1[B-1:0].
REQ-019 SHALL define the decrement recompute as: bit 0 = ~s1[0]; bit i = s1[i] XOR (AND of ~s1[j] for j<i).
REQ-020 SHALL, in that CALC cycle, update c to s1[B] when c=1, and to s1[B] AND (s1[B-1:0] != 0) when c=0.
REQ-021 SHALL advance k by 1 each CALC cycle; after processing k=NB-1, drive cout=c, set out_valid=1 and go to HOLD.
REQ-022 SHALL assert out_valid exactly NB cycles after the accepting edge; W=16, B=4 gives 4 cycles.
REQ-023 SHALL, in HOLD, keep sum, cout and out_valid stable until out_ready=1, then clear out_valid and go to IDLE on that edge.
REQ-024 SHALL drive in_ready=0 in CALC and HOLD, and ignore in_valid in those states; throughput is one operation per NB+2 cycles minimum.
REQ-025 SHALL keep out_valid=0 in IDLE and CALC; in_ready and out_valid are never both 1.
REQ-026 SHALL keep the final sum identical to (a+b+cin) mod 2^W and cout identical to bit W of a+b+cin, for all operands.

Reset
REQ-027 SHALL, on a clk edge with rst_n=0, set state=IDLE, k=0, c=0, in_ready=0, out_valid=0, sum=0 and cout=0, from any state.
REQ-028 SHALL register in_ready so that it first rises one cycle after rst_n returns to 1.
REQ-029 SHALL discard any in-flight operation on reset and produce no out_valid pulse for it.

Structure
REQ-030 SHALL place the FSM state encodings and the W/B defaults in the shared package csa_pkg.
REQ-031 SHALL isolate the REQ-019 decrement recompute, combinational and parameterised by B, in sub-module rb_dec.
REQ-032 SHALL keep all other logic (FSM, index counter, carry register, operand and sum registers) in csa_dec_serial.

Verification (W=16, B=4)
REQ-033 SHALL test a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0, out_valid 4 cycles after accept; every block uses the decrement path.
REQ-034 SHALL test a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry propagates through all 4 blocks.
REQ-035 SHALL test a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-036 SHALL test a=0x1234, b=0x4321, cin=0 with out_ready held low 3 cycles -> sum=0x5555 and cout=0 held stable, in_ready=0, and a second in_valid ignored until the HOLD handshake completes.
REQ-037 SHALL test rst_n=0 for one cycle after 2 CALC cycles -> next cycle out_valid=0 and sum=0x0000, in_ready=1 one cycle after release, and a following operation is correct.
REQ-038 SHALL test 10k random operands with random in_valid/out_ready stalls -> every result matches a+b+cin.
